// File: rtl/regfile_port_arbiter.sv
// Register file port arbiter: zero-initialises x1..x31 after reset, then
// grants one write or one two-operand read per cycle with round-robin per class.
module regfile_port_arbiter #(
    parameter int NREAD         = 2,
    parameter int NWRITE        = 2,
    parameter int WR_STREAK_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREAD-1:0]         rd_req,
    input  logic [NREAD*5-1:0]       rd_regA,
    input  logic [NREAD*5-1:0]       rd_regB,
    output logic [NREAD-1:0]         rd_gnt,
    output logic [NREAD-1:0]         rd_rsp_valid,
    output logic [31:0]              rd_dataA,
    output logic [31:0]              rd_dataB,
    input  logic [NWRITE-1:0]        wr_req,
    input  logic [NWRITE*5-1:0]      wr_reg,
    input  logic [NWRITE*32-1:0]     wr_data,
    output logic [NWRITE-1:0]        wr_gnt,
    output logic                     init_done,
    output logic [4:0]               rf_regA,
    output logic [4:0]               rf_regB,
    output logic [4:0]               rf_regW,
    output logic [31:0]              rf_dataIn,
    output logic                     rf_we,
    output logic                     rf_re,
    input  logic [31:0]              rf_outA,
    input  logic [31:0]              rf_outB
);

    localparam int RPW = (NREAD > 1) ? $clog2(NREAD) : 1;
    localparam int WPW = (NWRITE > 1) ? $clog2(NWRITE) : 1;
    localparam logic [3:0] SMAX = 4'(WR_STREAK_MAX);

    typedef enum logic [0:0] {
        INIT,
        RUN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_init_cnt;
    logic             r_init_done;
    logic [RPW-1:0]   r_rd_ptr;
    logic [RPW-1:0]   w_rd_ptr_nxt;
    logic [WPW-1:0]   r_wr_ptr;
    logic [WPW-1:0]   w_wr_ptr_nxt;
    logic [3:0]       r_streak;
    logic [3:0]       w_streak_nxt;
    logic [NREAD-1:0] r_rsp_valid;

    logic             w_any_rd;
    logic             w_any_wr;
    logic             w_do_wr;
    logic             w_do_rd;
    logic             w_rd_found;
    logic             w_wr_found;
    int               w_rd_idx;
    int               w_wr_idx;

    assign w_any_rd = |rd_req;
    assign w_any_wr = |wr_req;

    // Round-robin: first requester at or after the pointer, wrapping.
    always_comb begin
        w_rd_found = 1'b0;
        w_rd_idx   = 0;
        for (int k = 0; k < NREAD; k++) begin
            if (!w_rd_found && rd_req[(int'(r_rd_ptr) + k) % NREAD]) begin
                w_rd_found = 1'b1;
                w_rd_idx   = (int'(r_rd_ptr) + k) % NREAD;
            end
        end
    end

    always_comb begin
        w_wr_found = 1'b0;
        w_wr_idx   = 0;
        for (int k = 0; k < NWRITE; k++) begin
            if (!w_wr_found && wr_req[(int'(r_wr_ptr) + k) % NWRITE]) begin
                w_wr_found = 1'b1;
                w_wr_idx   = (int'(r_wr_ptr) + k) % NWRITE;
            end
        end
    end

    // Writes win unless a read has waited through a full streak.
    assign w_do_wr = (r_state == RUN) && w_any_wr
                     && !(w_any_rd && (r_streak == SMAX));
    assign w_do_rd = (r_state == RUN) && !w_do_wr && w_any_rd;

    always_comb begin
        w_state_nxt  = r_state;
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_streak_nxt = r_streak;
        rd_gnt       = '0;
        wr_gnt       = '0;
        rf_regA      = '0;
        rf_regB      = '0;
        rf_regW      = '0;
        rf_dataIn    = '0;
        rf_we        = 1'b0;
        rf_re        = 1'b0;

        if (r_state == INIT) begin
            rf_we   = 1'b1;
            rf_regW = r_init_cnt;
            if (r_init_cnt == 5'd31) begin
                w_state_nxt = RUN;
            end
        end else if (w_do_wr) begin
            wr_gnt[w_wr_idx] = 1'b1;
            rf_we            = 1'b1;
            rf_regW          = wr_reg[5*w_wr_idx +: 5];
            rf_dataIn        = wr_data[32*w_wr_idx +: 32];
            if (w_wr_idx == NWRITE - 1) begin
                w_wr_ptr_nxt = '0;
            end else begin
                w_wr_ptr_nxt = WPW'(w_wr_idx + 1);
            end
        end else if (w_do_rd) begin
            rd_gnt[w_rd_idx] = 1'b1;
            rf_re            = 1'b1;
            rf_regA          = rd_regA[5*w_rd_idx +: 5];
            rf_regB          = rd_regB[5*w_rd_idx +: 5];
            if (w_rd_idx == NREAD - 1) begin
                w_rd_ptr_nxt = '0;
            end else begin
                w_rd_ptr_nxt = RPW'(w_rd_idx + 1);
            end
        end

        if (w_do_wr && w_any_rd) begin
            if (r_streak != SMAX) begin
                w_streak_nxt = r_streak + 4'd1;
            end
        end else if (w_do_rd || !w_any_rd) begin
            w_streak_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= INIT;
            r_init_cnt  <= 5'd1;
            r_init_done <= 1'b0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_streak    <= '0;
            r_rsp_valid <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_done <= (w_state_nxt == RUN);
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_streak    <= w_streak_nxt;
            r_rsp_valid <= rd_gnt;
            if (r_state == INIT) begin
                r_init_cnt <= r_init_cnt + 5'd1;
            end
        end
    end

    assign init_done    = r_init_done;
    assign rd_rsp_valid = r_rsp_valid;
    assign rd_dataA     = (|r_rsp_valid) ? rf_outA : '0;
    assign rd_dataB     = (|r_rsp_valid) ? rf_outB : '0;

endmodule
